// File: rtl/load_store_unit.sv
// Data-memory front end: one load/store at a time, word accesses to a synchronous
// memory, read-modify-write for byte stores, formatted load data on a response channel.
//
// state | meaning
// IDLE  | ready for a request
// RD    | read strobe to memory
// CAP   | memory data valid; format load result or merge byte-store word
// WR    | full-word write strobe
// RESP  | response held until consumer accepts
module load_store_unit #(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic              req_byte,
  input  logic              req_signed,
  input  logic [ADDR_W+1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_re,
  output logic              mem_we,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [2:0] {IDLE, RD, CAP, WR, RESP} state_t;

  state_t            state, state_nxt;
  logic              l_write, l_byte, l_signed;
  logic [ADDR_W+1:0] l_addr;
  logic [7:0]        l_wbyte;
  logic [31:0]       wbuf;
  logic              accept, misaligned;
  logic [31:0]       shifted, load_fmt, merged;
  logic [7:0]        lane_byte;

  assign accept     = req_valid && req_ready;
  assign misaligned = !req_byte && (req_addr[1:0] != 2'b00);
  assign mem_addr   = l_addr[ADDR_W+1:2];
  assign mem_wdata  = wbuf;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    req_ready  = 1'b0;
    mem_re     = 1'b0;
    mem_we     = 1'b0;
    resp_valid = 1'b0;
    case (state)
      IDLE: begin
        req_ready = reset_n;
        if (req_valid) begin
          if (misaligned)                  state_nxt = RESP;
          else if (!req_write || req_byte) state_nxt = RD;
          else                             state_nxt = WR;
        end
      end
      RD: begin
        mem_re    = 1'b1;
        state_nxt = CAP;
      end
      CAP:     state_nxt = l_write ? WR : RESP;
      WR: begin
        mem_we    = 1'b1;
        state_nxt = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Little-endian lane select and extension of the returned word
  always_comb begin
    shifted   = mem_rdata >> {l_addr[1:0], 3'b000};
    lane_byte = shifted[7:0];
    if (l_byte) load_fmt = {{24{l_signed & lane_byte[7]}}, lane_byte};
    else        load_fmt = mem_rdata;
  end

  always_comb begin
    merged = mem_rdata;
    case (l_addr[1:0])
      2'd0:    merged[7:0]   = l_wbyte;
      2'd1:    merged[15:8]  = l_wbyte;
      2'd2:    merged[23:16] = l_wbyte;
      default: merged[31:24] = l_wbyte;
    endcase
  end

  // wbuf doubles as the write-data register so mem_wdata only moves on an accept or merge
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      l_write    <= 1'b0;
      l_byte     <= 1'b0;
      l_signed   <= 1'b0;
      l_addr     <= '0;
      l_wbyte    <= 8'h00;
      wbuf       <= 32'h0;
      resp_rdata <= 32'h0;
      resp_err   <= 1'b0;
    end else if (accept) begin
      l_write    <= req_write;
      l_byte     <= req_byte;
      l_signed   <= req_signed;
      l_addr     <= req_addr;
      l_wbyte    <= req_wdata[7:0];
      resp_rdata <= 32'h0;
      resp_err   <= misaligned;
      if (req_write && !req_byte && !misaligned) wbuf <= req_wdata;
    end else if (state == CAP) begin
      if (l_write) wbuf       <= merged;
      else         resp_rdata <= load_fmt;
    end
  end

endmodule
